mrv32_ctrl: RTL and testbench
=============================

# mrv32_ctrl

Multi-cycle sequencer for the blocking MRV32 core. Owns the architectural PC and steps exactly one instruction at a time through FETCH, DECODE, EXEC, optional MEM, and WB. It issues the one-cycle stage-valid tokens and the level-held memory requests, and consumes the WB-stage commit (`instr_accept`, `pc_next`). Illegal instructions, halts, misaligned targets and bus timeouts park it in sticky terminal states.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `TIMEOUT_CYCLES`, default 256: maximum wait cycles in FETCH/MEM before a fault; 0 disables the watchdog.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `run_en`  in  1  permit to start the next instruction.
- `imem_req`  out  1  instruction fetch request, level.
- `imem_addr`  out  32  fetch address, always equal to `pc`.
- `imem_ack`  in  1  fetch complete; instruction valid this cycle.
- `id_valid`  out  1  one-cycle pulse: decoder latches the instruction.
- `dec_illegal`  in  1  decoder flag, sampled in DECODE.
- `dec_halt`  in  1  ECALL/EBREAK flag, sampled in DECODE.
- `dec_mem_ren`  in  1  load flag, sampled in EXEC.
- `dec_mem_wen`  in  1  store flag, sampled in EXEC.
- `ex_valid`  out  1  one-cycle pulse: EX results latched.
- `dmem_req`  out  1  data access request, level.
- `dmem_ack`  in  1  data access complete.
- `wb_valid`  out  1  one-cycle pulse to the WB stage.
- `instr_accept`  in  1  commit from WB, combinational in the same cycle.
- `pc_next`  in  32  next PC from WB, valid with `instr_accept`.
- `pc`  out  32  PC of the current instruction.
- `state`  out  3  FSM state code, for debug.
- `halted`  out  1  in HALT.
- `fault`  out  1  in FAULT.
- `fault_cause`  out  3  0 none, 1 illegal, 2 misaligned `pc_next`, 3 imem timeout, 4 dmem timeout, 5 missing commit.
- `cycle_cnt`  out  64  performance counter (see Configuration).
- `instret_cnt`  out  64  performance counter (see Configuration).

## Operation
- State codes: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, FAULT=7.
- IDLE: `run_en`=1 → FETCH; otherwise stay.
- FETCH: `imem_req`=1, `imem_addr` stable. `imem_ack` → DECODE. An ack in the first FETCH cycle is accepted.
- DECODE: `id_valid`=1. Transitions in priority order:
  - `dec_illegal` → FAULT, cause 1.
  - `dec_halt` → HALT.
  - otherwise → EXEC.
- EXEC: `ex_valid`=1. `dec_mem_ren|dec_mem_wen` → MEM; otherwise → WB.
- MEM: `dmem_req`=1 until `dmem_ack` → WB.
- WB: `wb_valid`=1. Checks in priority order:
  - `instr_accept`=0 → FAULT, cause 5.
  - `pc_next[1:0]`≠0 → FAULT, cause 2; `pc` is not updated.
  - otherwise `pc`←`pc_next`, then → FETCH if `run_en`, else → IDLE.
- `run_en` is sampled only in IDLE and WB. Deasserting it mid-instruction lets the instruction complete.
- Watchdog: counter clears on entry to FETCH/MEM and increments each waiting cycle. When the count reaches `TIMEOUT_CYCLES` with no ack → FAULT, cause 3 or 4; the request drops the next cycle.
- `imem_ack`/`dmem_ack` outside FETCH/MEM are ignored.
- HALT and FAULT are sticky until `rst_n`. All pulses and requests are 0 there. `pc` holds the PC of the offending instruction.
- Outputs are registered or decoded from the state register only; no input-to-output combinational path.

## Timing
- Reset (async assert, sync deassert by the system): state=IDLE, `pc`=`imem_addr`=RESET_PC. All other outputs 0, counters 0.
- Reset mid-operation drops `imem_req`/`dmem_req` immediately. An in-flight ack after reset is ignored.
- Non-memory instruction with zero-wait fetch: 4 cycles (FETCH, DECODE, EXEC, WB). Load/store with zero-wait fetch and data: 5 cycles. Each wait cycle adds 1.
- Back-to-back: FETCH of the next instruction starts the cycle after WB, using the updated `pc`.
- `pc` wraps modulo 2^32; `pc_next`=32'h0000_0000 is legal.

## Configuration
- `MRV32_PERF_CNT_EN` defined:
  - `cycle_cnt` increments every cycle while state ∉ {IDLE, HALT, FAULT}.
  - `instret_cnt` increments on each successful WB commit.
  - Both are 64-bit and wrap.
- Undefined: both ports are tied to 0 and no counter flops exist.

## Test plan
- Reset RESET_PC=32'h100, `run_en`=1, zero-wait acks, non-memory instruction, `pc_next`=32'h104 → `id_valid`/`ex_valid`/`wb_valid` pulse in cycles 2/3/4; `imem_addr`=32'h104 in cycle 5.
- Load, `imem_ack` after 2 waits, `dmem_ack` after 3 waits → `wb_valid` 10 cycles after FETCH entry; `instret_cnt`=1 with the macro defined.
- `dec_illegal`=1 in DECODE → FAULT, `fault_cause`=1, `pc` unchanged, `imem_req` stays 0 afterwards.
- TIMEOUT_CYCLES=4, `dmem_ack` never arrives → FAULT with cause 4 after 4 MEM cycles; `dmem_req` deasserted.
- WB with `pc_next`=32'h102 → FAULT cause 2. WB with `instr_accept`=0 → FAULT cause 5.
- `run_en` dropped during EXEC → instruction commits, FSM enters IDLE. `rst_n` pulsed in MEM → IDLE, `pc`=RESET_PC, `dmem_req`=0 immediately.

Source files
------------

// File: rtl/mrv32_ctrl_if.sv
// Memory handshake bundle between the MRV32 sequencer and its instruction and
// data memory ports. The sequencer is the master: it raises level-held requests
// and receives single-cycle acks.
interface mrv32_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic        dmem_req;
  logic        dmem_ack;

  modport master (
    output imem_req, imem_addr, dmem_req,
    input  imem_ack, dmem_ack
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req,
    output imem_ack, dmem_ack
  );
endinterface

// File: rtl/mrv32_ctrl.sv
// mrv32_ctrl: multi-cycle sequencer for the blocking MRV32 core.
// Steps one instruction at a time through FETCH, DECODE, EXEC, optional MEM
// and WB, owns the architectural PC, and parks in sticky HALT/FAULT states.
// Optional feature macro: MRV32_PERF_CNT_EN enables the 64-bit cycle and
// retired-instruction counters; without it both counter ports read 0.
module mrv32_ctrl #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         run_en,
  mrv32_ctrl_if.master bus,
  output logic         id_valid,
  input  logic         dec_illegal,
  input  logic         dec_halt,
  input  logic         dec_mem_ren,
  input  logic         dec_mem_wen,
  output logic         ex_valid,
  output logic         wb_valid,
  input  logic         instr_accept,
  input  logic [31:0]  pc_next,
  output logic [31:0]  pc,
  output logic [2:0]   state,
  output logic         halted,
  output logic         fault,
  output logic [2:0]   fault_cause,
  output logic [63:0]  cycle_cnt,
  output logic [63:0]  instret_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_FAULT  = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    C_NONE      = 3'd0,
    C_ILLEGAL   = 3'd1,
    C_MISALIGN  = 3'd2,
    C_IMEM_TO   = 3'd3,
    C_DMEM_TO   = 3'd4,
    C_NO_COMMIT = 3'd5
  } cause_e;

  // Watchdog counts completed wait cycles 0..TIMEOUT_CYCLES-1; the cycle in
  // which it sits at the last value without an ack is the one that faults.
  localparam bit              WD_EN   = (TIMEOUT_CYCLES != 0);
  localparam int              WD_W    = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_EN ? WD_W'(TIMEOUT_CYCLES - 1) : '0;

  state_e          state_q, state_d;
  cause_e          cause_q, cause_d;
  logic            commit;
  logic [WD_W-1:0] wd_cnt;
  logic            wd_expired;

  assign wd_expired = WD_EN && (wd_cnt == WD_LAST);

  // Next-state, fault cause and commit decode.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case can leave it unassigned and infer a latch.
    state_d = state_q;
    cause_d = cause_q;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: if (run_en) state_d = S_FETCH;
      S_FETCH: begin
        if (bus.imem_ack) begin
          state_d = S_DECODE;
        end else if (wd_expired) begin
          state_d = S_FAULT;
          cause_d = C_IMEM_TO;
        end
      end
      S_DECODE: begin
        if (dec_illegal) begin
          state_d = S_FAULT;
          cause_d = C_ILLEGAL;
        end else if (dec_halt) begin
          state_d = S_HALT;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: state_d = (dec_mem_ren || dec_mem_wen) ? S_MEM : S_WB;
      S_MEM: begin
        if (bus.dmem_ack) begin
          state_d = S_WB;
        end else if (wd_expired) begin
          state_d = S_FAULT;
          cause_d = C_DMEM_TO;
        end
      end
      S_WB: begin
        if (!instr_accept) begin
          state_d = S_FAULT;
          cause_d = C_NO_COMMIT;
        end else if (pc_next[1:0] != 2'b00) begin
          state_d = S_FAULT;
          cause_d = C_MISALIGN;
        end else begin
          commit  = 1'b1;
          state_d = run_en ? S_FETCH : S_IDLE;
        end
      end
      S_HALT, S_FAULT: ;  // terminal until reset
    endcase
  end

  // State and fault-cause registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cause_q <= C_NONE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  // Architectural PC: only a clean WB commit moves it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (commit) begin
      pc <= pc_next;
    end
  end

  // Wait-cycle watchdog: cleared on every state change, counts while parked
  // waiting for an ack in FETCH or MEM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (state_d != state_q) begin
      wd_cnt <= '0;
    end else if (WD_EN && ((state_q == S_FETCH) || (state_q == S_MEM))) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  // All outputs decode from registers only; no input reaches an output
  // combinationally.
  assign bus.imem_req  = (state_q == S_FETCH);
  assign bus.imem_addr = pc;
  assign bus.dmem_req  = (state_q == S_MEM);
  assign id_valid      = (state_q == S_DECODE);
  assign ex_valid      = (state_q == S_EXEC);
  assign wb_valid      = (state_q == S_WB);
  assign state         = state_q;
  assign halted        = (state_q == S_HALT);
  assign fault         = (state_q == S_FAULT);
  assign fault_cause   = cause_q;

`ifdef MRV32_PERF_CNT_EN
  logic [63:0] cycle_q;
  logic [63:0] instret_q;

  // Performance counters: busy cycles and committed instructions, both wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      if (!(state_q inside {S_IDLE, S_HALT, S_FAULT})) cycle_q <= cycle_q + 64'd1;
      if (commit) instret_q <= instret_q + 64'd1;
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_mrv32_ctrl.sv
// Self-checking bench for mrv32_ctrl. A table of instruction records drives a
// reactive memory/decoder/WB environment; fetch addresses are predicted into a
// scoreboard queue when WB commits and popped when the next fetch appears.
// Hand-written sequences cover sticky FAULT and reset during a data access.
module tb_mrv32_ctrl;
  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int          TO     = 4;

  localparam int ST_IDLE = 0, ST_FETCH = 1, ST_DECODE = 2, ST_EXEC = 3,
                 ST_MEM  = 4, ST_WB    = 5, ST_HALT   = 6, ST_FAULT = 7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run_en;
  logic        dec_illegal, dec_halt, dec_mem_ren, dec_mem_wen;
  logic        instr_accept;
  logic [31:0] pc_next;
  logic        id_valid, ex_valid, wb_valid, halted, fault;
  logic [31:0] pc;
  logic [2:0]  state, fault_cause;
  logic [63:0] cycle_cnt, instret_cnt;

  mrv32_ctrl_if bus ();

  mrv32_ctrl #(.RESET_PC(RST_PC), .TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run_en       (run_en),
    .bus          (bus),
    .id_valid     (id_valid),
    .dec_illegal  (dec_illegal),
    .dec_halt     (dec_halt),
    .dec_mem_ren  (dec_mem_ren),
    .dec_mem_wen  (dec_mem_wen),
    .ex_valid     (ex_valid),
    .wb_valid     (wb_valid),
    .instr_accept (instr_accept),
    .pc_next      (pc_next),
    .pc           (pc),
    .state        (state),
    .halted       (halted),
    .fault        (fault),
    .fault_cause  (fault_cause),
    .cycle_cnt    (cycle_cnt),
    .instret_cnt  (instret_cnt)
  );

  always #5 clk = ~clk;

  // One instruction: stimulus followed by expected results.
  typedef struct {
    int          rst;      // pulse reset before this record
    int          iw;       // imem wait cycles (>= TO means never ack)
    int          mem;      // load/store
    int          wr;       // store rather than load
    int          dw;       // dmem wait cycles
    int          ill;
    int          hlt;
    int          acc;      // instr_accept in WB
    logic [31:0] nxt;      // pc_next in WB
    int          run_wb;   // run_en driven in WB
    int          drop_ex;  // drop run_en in EXEC
    int          e_ireq;   // cycles with imem_req
    int          e_dreq;   // cycles with dmem_req
    int          e_id;     // cycle index of id_valid (FETCH entry = 1), 0 = none
    int          e_wb;     // cycle index of wb_valid, 0 = none
    int          e_st;     // state after the record
    logic [31:0] e_pc;
    int          e_cause;
    int          e_len;    // busy cycles added to cycle_cnt
  } vec_t;

  vec_t vecs [14];

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_addr_q [$];
  logic [63:0] cyc_m, ret_m;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    run_en       = 1'b0;
    dec_illegal  = 1'b0;
    dec_halt     = 1'b0;
    dec_mem_ren  = 1'b0;
    dec_mem_wen  = 1'b0;
    instr_accept = 1'b0;
    pc_next      = '0;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_state", 64'(state), 64'(ST_IDLE));
    check("rst_pc", 64'(pc), 64'(RST_PC));
    check("rst_addr", 64'(bus.imem_addr), 64'(RST_PC));
    check("rst_outs", 64'({bus.imem_req, bus.dmem_req, id_valid, ex_valid, wb_valid,
                           halted, fault, fault_cause}), 64'd0);
    check("rst_cycle", cycle_cnt, 64'd0);
    check("rst_instret", instret_cnt, 64'd0);
    rst_n = 1'b1;
    exp_addr_q.delete();
    exp_addr_q.push_back(RST_PC);
    cyc_m = '0;
    ret_m = '0;
  endtask

  task automatic run_rec(input vec_t v, input int idx);
    string tag;
    int    cyc = 0, n_i = 0, n_d = 0, id_at = 0, ex_at = 0, wb_at = 0;
    int    f_cnt = 0, m_cnt = 0;
    bit    done = 1'b0;
    int    st;
    int    e_ex;
    tag = $sformatf("v%0d", idx);
    if (v.rst != 0) do_reset();
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk);
      st = int'(state);
      bus.imem_ack = 1'b0;
      bus.dmem_ack = 1'b0;
      dec_illegal  = 1'b0;
      dec_halt     = 1'b0;
      dec_mem_ren  = 1'b0;
      dec_mem_wen  = 1'b0;
      instr_accept = 1'b0;
      pc_next      = '0;
      if (st >= ST_FETCH && st <= ST_WB) cyc++;
      if (bus.imem_req) n_i++;
      if (bus.dmem_req) n_d++;
      if (id_valid) id_at = cyc;
      if (ex_valid) ex_at = cyc;
      if (wb_valid) wb_at = cyc;
      case (st)
        ST_IDLE: run_en = 1'b1;
        ST_FETCH: begin
          if (f_cnt == 0) begin
            if (exp_addr_q.size() != 0) begin
              check({tag, "_fetch_addr"}, 64'(bus.imem_addr), 64'(exp_addr_q.pop_front()));
            end else begin
              n_cmp++;
              n_bad++;
              $display("FAIL %s_fetch_addr: got 0x%0h expected none queued", tag, bus.imem_addr);
            end
          end
          bus.imem_ack = (f_cnt == v.iw);
          f_cnt++;
        end
        ST_DECODE: begin
          dec_illegal = (v.ill != 0);
          dec_halt    = (v.hlt != 0);
          if (v.ill != 0 || v.hlt != 0) done = 1'b1;
        end
        ST_EXEC: begin
          dec_mem_ren = (v.mem != 0) && (v.wr == 0);
          dec_mem_wen = (v.mem != 0) && (v.wr != 0);
          if (v.drop_ex != 0) run_en = 1'b0;
        end
        ST_MEM: begin
          bus.dmem_ack = (m_cnt == v.dw);
          m_cnt++;
        end
        ST_WB: begin
          instr_accept = (v.acc != 0);
          pc_next      = v.nxt;
          run_en       = (v.run_wb != 0);
          if (v.acc != 0 && v.nxt[1:0] == 2'b00) exp_addr_q.push_back(v.nxt);
          done = 1'b1;
        end
        default: done = 1'b1;
      endcase
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got no end of instruction expected one within 60 cycles", tag);
    end
    @(posedge clk);
    #1;
    e_ex = (v.e_id == 0 || v.ill != 0 || v.hlt != 0) ? 0 : v.e_id + 1;
    check({tag, "_state"}, 64'(state), 64'(v.e_st));
    check({tag, "_pc"}, 64'(pc), 64'(v.e_pc));
    check({tag, "_cause"}, 64'(fault_cause), 64'(v.e_cause));
    check({tag, "_ireq_cycles"}, 64'(n_i), 64'(v.e_ireq));
    check({tag, "_dreq_cycles"}, 64'(n_d), 64'(v.e_dreq));
    check({tag, "_id_at"}, 64'(id_at), 64'(v.e_id));
    check({tag, "_ex_at"}, 64'(ex_at), 64'(e_ex));
    check({tag, "_wb_at"}, 64'(wb_at), 64'(v.e_wb));
    check({tag, "_flags"}, 64'({halted, fault}),
          64'({v.e_st == ST_HALT, v.e_st == ST_FAULT}));
    if (v.e_st == ST_HALT || v.e_st == ST_FAULT) begin
      check({tag, "_quiet"}, 64'({bus.imem_req, bus.dmem_req, id_valid, ex_valid, wb_valid}), 64'd0);
    end
    cyc_m = cyc_m + 64'(v.e_len);
    if (v.e_wb != 0 && v.e_st != ST_FAULT) ret_m = ret_m + 64'd1;
`ifdef MRV32_PERF_CNT_EN
    check({tag, "_cycle_cnt"}, cycle_cnt, cyc_m);
    check({tag, "_instret_cnt"}, instret_cnt, ret_m);
`else
    check({tag, "_cycle_cnt"}, cycle_cnt, 64'd0);
    check({tag, "_instret_cnt"}, instret_cnt, 64'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected one before 200000 time units");
    $fatal(1, "bench time limit");
  end

  initial begin
    vec_t v;
    int   pulses;
    rst_n = 1'b0;
    clear_inputs();

    //        rst iw  mem wr dw  ill hlt acc nxt            rwb dex  ireq dreq id wb  state     pc             cause len
    vecs[0]  = '{1, 0,  0, 0, 0,  0,  0,  1, 32'h0000_0104, 1, 0,   1,   0,  2, 4,  ST_FETCH, 32'h0000_0104, 0, 4};
    vecs[1]  = '{0, 2,  1, 0, 3,  0,  0,  1, 32'h0000_0200, 1, 0,   3,   4,  4, 10, ST_FETCH, 32'h0000_0200, 0, 10};
    vecs[2]  = '{0, 0,  1, 1, 0,  0,  0,  1, 32'h0000_0000, 1, 0,   1,   1,  2, 5,  ST_FETCH, 32'h0000_0000, 0, 5};
    vecs[3]  = '{0, 1,  0, 0, 0,  0,  0,  1, 32'hFFFF_FFFC, 1, 0,   2,   0,  3, 5,  ST_FETCH, 32'hFFFF_FFFC, 0, 5};
    vecs[4]  = '{0, 0,  0, 0, 0,  0,  0,  1, 32'h0000_0008, 0, 1,   1,   0,  2, 4,  ST_IDLE,  32'h0000_0008, 0, 4};
    vecs[5]  = '{0, 3,  0, 0, 0,  0,  0,  1, 32'h0000_0010, 1, 0,   4,   0,  5, 7,  ST_FETCH, 32'h0000_0010, 0, 7};
    vecs[6]  = '{0, 0,  0, 0, 0,  1,  0,  1, 32'h0000_0000, 1, 0,   1,   0,  2, 0,  ST_FAULT, 32'h0000_0010, 1, 2};
    vecs[7]  = '{1, 0,  0, 0, 0,  0,  1,  1, 32'h0000_0000, 1, 0,   1,   0,  2, 0,  ST_HALT,  32'h0000_0100, 0, 2};
    vecs[8]  = '{1, 0,  0, 0, 0,  1,  1,  1, 32'h0000_0000, 1, 0,   1,   0,  2, 0,  ST_FAULT, 32'h0000_0100, 1, 2};
    vecs[9]  = '{1, 0,  1, 0, 99, 0,  0,  1, 32'h0000_0000, 1, 0,   1,   4,  2, 0,  ST_FAULT, 32'h0000_0100, 4, 7};
    vecs[10] = '{1, 99, 0, 0, 0,  0,  0,  1, 32'h0000_0000, 1, 0,   4,   0,  0, 0,  ST_FAULT, 32'h0000_0100, 3, 4};
    vecs[11] = '{1, 0,  0, 0, 0,  0,  0,  1, 32'h0000_0102, 1, 0,   1,   0,  2, 4,  ST_FAULT, 32'h0000_0100, 2, 4};
    vecs[12] = '{1, 0,  0, 0, 0,  0,  0,  0, 32'h0000_0104, 1, 0,   1,   0,  2, 4,  ST_FAULT, 32'h0000_0100, 5, 4};
    vecs[13] = '{1, 0,  0, 0, 0,  0,  0,  0, 32'h0000_0103, 1, 0,   1,   0,  2, 4,  ST_FAULT, 32'h0000_0100, 5, 4};

    for (int i = 0; i < 14; i++) run_rec(vecs[i], i);

    // FAULT is sticky: hammer every input for several cycles, nothing moves.
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      run_en       = 1'b1;
      bus.imem_ack = 1'b1;
      bus.dmem_ack = 1'b1;
      instr_accept = 1'b1;
      pc_next      = 32'h0000_0200;
      if (bus.imem_req || bus.dmem_req || id_valid || ex_valid || wb_valid) pulses++;
    end
    @(negedge clk);
    check("sticky_state", 64'(state), 64'(ST_FAULT));
    check("sticky_cause", 64'(fault_cause), 64'd5);
    check("sticky_pc", 64'(pc), 64'(RST_PC));
    check("sticky_activity", 64'(pulses), 64'd0);

    // Reset asserted in MEM: requests drop at once, PC reloads, late acks ignored.
    do_reset();
    v = '{0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0300, 1, 0, 1, 0, 2, 4, ST_FETCH, 32'h0000_0300, 0, 4};
    run_rec(v, 14);
    @(negedge clk);
    clear_inputs();
    run_en       = 1'b1;
    bus.imem_ack = 1'b1;                 // FETCH
    @(negedge clk);
    bus.imem_ack = 1'b0;                 // DECODE
    @(negedge clk);
    dec_mem_ren  = 1'b1;                 // EXEC
    @(negedge clk);
    dec_mem_ren  = 1'b0;                 // MEM, no ack
    check("mem_state", 64'(state), 64'(ST_MEM));
    check("mem_dreq", 64'(bus.dmem_req), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_dreq", 64'(bus.dmem_req), 64'd0);
    check("async_rst_state", 64'(state), 64'(ST_IDLE));
    check("async_rst_pc", 64'(bus.imem_addr), 64'(RST_PC));
    bus.dmem_ack = 1'b1;
    bus.imem_ack = 1'b1;
    run_en       = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_state", 64'(state), 64'(ST_IDLE));
    check("post_rst_reqs", 64'({bus.imem_req, bus.dmem_req}), 64'd0);
    check("post_rst_pc", 64'(pc), 64'(RST_PC));
    clear_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
